raster_req_arb: RTL and testbench

- Round-robin arbiter that merges NUM_INPUTS raster request streams into one downstream raster request stream. Each stream carries valid, NUM_LANES stamps, done and ready.
- Sits between the per-cluster raster units and the shared core-side raster request port.
- Registers the selected beat in a single output stage.
- Aggregates per-input done flags into one end-of-frame done.
- Keeps a forwarded-beat counter.

---
 rtl/raster_req_arb.sv | 158 +++++++++++++++
 tb/tb_raster_req_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/raster_req_arb.sv
// raster_req_arb: round-robin merge of NUM_INPUTS raster request streams into a
// single registered downstream raster request stream.
//
// Ports:
//   clk, reset       - clock and synchronous active-high reset
//   clear            - frame restart pulse; clears the done mask and out_done
//   in_valid         - per-input beat valid
//   in_stamps        - per-input stamps, input i occupies slice i
//   in_done          - per-input "no more stamps this frame"
//   in_ready         - per-input accept (combinational, granted input only)
//   out_valid        - registered beat valid
//   out_stamps       - registered beat stamps
//   out_done         - registered: all inputs done and output stage empty
//   out_ready        - downstream accept
//   beat_count       - number of beats accepted downstream (wrapping)
module raster_req_arb #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned NUM_LANES  = 1,
  parameter int unsigned STAMP_W    = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    clear,
  input  logic [NUM_INPUTS-1:0]                   in_valid,
  input  logic [NUM_INPUTS*NUM_LANES*STAMP_W-1:0] in_stamps,
  input  logic [NUM_INPUTS-1:0]                   in_done,
  output logic [NUM_INPUTS-1:0]                   in_ready,
  output logic                                    out_valid,
  output logic [NUM_LANES*STAMP_W-1:0]            out_stamps,
  output logic                                    out_done,
  input  logic                                    out_ready,
  output logic [CNT_W-1:0]                        beat_count
);

  localparam int unsigned BEAT_W = NUM_LANES * STAMP_W;
  localparam int unsigned IDX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic [IDX_W-1:0]      r_ptr;
  logic                  r_out_valid;
  logic [BEAT_W-1:0]     r_out_stamps;
  logic                  r_out_done;
  logic [NUM_INPUTS-1:0] r_done_mask;
  logic [CNT_W-1:0]      r_beat_count;

  logic [IDX_W-1:0]      w_grant;
  logic                  w_grant_vld;
  int unsigned           w_idx;
  logic                  w_stage_free;
  logic                  w_xfer_in;
  logic                  w_xfer_out;
  logic [BEAT_W-1:0]     w_sel_stamps;
  logic [IDX_W-1:0]      w_ptr_next;

  // Cyclic search for the first valid input at or after the pointer.
  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    w_idx       = 0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      w_idx = (int'(r_ptr) + k) % NUM_INPUTS;
      if (!w_grant_vld && in_valid[IDX_W'(w_idx)]) begin
        w_grant_vld = 1'b1;
        w_grant     = IDX_W'(w_idx);
      end
    end
  end

  assign w_stage_free = !r_out_valid || out_ready;
  // Reset gates the accept so nothing is taken in the reset cycle.
  assign w_xfer_in    = w_grant_vld && w_stage_free && !reset;
  assign w_xfer_out   = r_out_valid && out_ready;

  // Ready only towards the granted input.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      in_ready[i] = w_xfer_in && (w_grant == IDX_W'(i));
    end
  end

  // Stamp mux for the granted input.
  always_comb begin
    w_sel_stamps = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (w_grant == IDX_W'(i)) begin
        w_sel_stamps = in_stamps[i*BEAT_W +: BEAT_W];
      end
    end
  end

  // Pointer moves one past the granted input, wrapping at the last input.
  always_comb begin
    w_ptr_next = r_ptr;
    if (w_xfer_in) begin
      if (w_grant == IDX_W'(NUM_INPUTS - 1)) begin
        w_ptr_next = '0;
      end else begin
        w_ptr_next = w_grant + IDX_W'(1);
      end
    end
  end

  // Round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  // Single-entry output stage; stamps hold when drained without refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_stamps <= '0;
    end else if (w_xfer_in) begin
      r_out_valid  <= 1'b1;
      r_out_stamps <= w_sel_stamps;
    end else if (w_xfer_out) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Sticky done mask; clear takes priority over incoming done flags.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_done_mask <= '0;
    end else begin
      r_done_mask <= r_done_mask | in_done;
    end
  end

  // End-of-frame done, held off while a beat is still buffered.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_out_done <= 1'b0;
    end else begin
      r_out_done <= (&r_done_mask) && !r_out_valid;
    end
  end

  // Downstream beat counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_count <= '0;
    end else if (w_xfer_out) begin
      r_beat_count <= r_beat_count + CNT_W'(1);
    end
  end

  assign out_valid  = r_out_valid;
  assign out_stamps = r_out_stamps;
  assign out_done   = r_out_done;
  assign beat_count = r_beat_count;

endmodule

// File: tb/tb_raster_req_arb.sv
// Directed testbench for raster_req_arb (4 inputs, 16-bit stamps, 4-bit counter).
module tb_raster_req_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned L  = 1;
  localparam int unsigned SW = 16;
  localparam int unsigned CW = 4;

  logic              clk;
  logic              reset;
  logic              clear;
  logic [N-1:0]      in_valid;
  logic [N*L*SW-1:0] in_stamps;
  logic [N-1:0]      in_done;
  logic [N-1:0]      in_ready;
  logic              out_valid;
  logic [L*SW-1:0]   out_stamps;
  logic              out_done;
  logic              out_ready;
  logic [CW-1:0]     beat_count;

  int n_checks;
  int n_pass;

  raster_req_arb #(
    .NUM_INPUTS(N),
    .NUM_LANES (L),
    .STAMP_W   (SW),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_stamps (in_stamps),
    .in_done   (in_done),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_stamps(out_stamps),
    .out_done  (out_done),
    .out_ready (out_ready),
    .beat_count(beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, req);
    end
  endtask

  // Advance past the next rising edge; inputs are driven here, checks follow after #1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_stamp(input int i, input logic [SW-1:0] v);
    in_stamps[i*SW +: SW] = v;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = '0;
    in_stamps = '0;
    in_done   = '0;
    out_ready = 1'b0;

    // Reset then idle
    step();
    step();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_done", 32'(out_done), 32'd0);
    check("rst_beat_count", 32'(beat_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    reset = 1'b0;
    step();
    #1;
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'h0);

    // Round-robin fairness: all inputs valid, stamp = index
    for (int i = 0; i < int'(N); i++) set_stamp(i, SW'(i));
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    check("rr_first_ready", 32'(in_ready), 32'b0001);
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 7) in_valid = '0;
      #1;
      check($sformatf("rr_stamp_%0d", k), 32'(out_stamps), 32'(k % 4));
      check($sformatf("rr_valid_%0d", k), 32'(out_valid), 32'd1);
    end
    step();
    #1;
    check("rr_count8", 32'(beat_count), 32'd8);
    check("rr_drained", 32'(out_valid), 32'd0);

    // Backpressure on input 2
    out_ready = 1'b0;
    set_stamp(2, 16'h0022);
    in_valid = 4'b0100;
    #1;
    check("bp_ready_pre", 32'(in_ready), 32'b0100);
    step();
    set_stamp(2, 16'h0023);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_valid_%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("bp_stamp_%0d", k), 32'(out_stamps), 32'h0022);
      check($sformatf("bp_ready_%0d", k), 32'(in_ready), 32'h0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_release", 32'(in_ready), 32'b0100);
    step();
    in_valid = '0;
    #1;
    check("bp_next_stamp", 32'(out_stamps), 32'h0023);
    check("bp_count", 32'(beat_count), 32'd9);
    step();
    #1;
    check("bp_count_drain", 32'(beat_count), 32'd10);
    check("bp_valid_drain", 32'(out_valid), 32'd0);

    // Skip empty inputs: move ptr to 1, then in_valid=1001
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 4'b0001;
    set_stamp(0, 16'h00a0);
    set_stamp(3, 16'h00a3);
    step();
    in_valid = 4'b1001;
    #1;
    check("skip_grant3_a", 32'(in_ready), 32'b1000);
    step();
    #1;
    check("skip_out_a3", 32'(out_stamps), 32'h00a3);
    check("skip_grant0", 32'(in_ready), 32'b0001);
    step();
    #1;
    check("skip_out_a0", 32'(out_stamps), 32'h00a0);
    check("skip_grant3_b", 32'(in_ready), 32'b1000);
    step();
    in_valid = '0;
    #1;
    check("skip_out_a3_b", 32'(out_stamps), 32'h00a3);
    step();
    #1;
    check("skip_count", 32'(beat_count), 32'd4);

    // Done aggregation with a final beat stuck behind backpressure
    out_ready = 1'b0;
    in_done   = 4'b0111;
    step();
    #1;
    check("done_partial", 32'(out_done), 32'd0);
    in_done  = 4'b1111;
    in_valid = 4'b1000;
    set_stamp(3, 16'h00d3);
    #1;
    check("done_last_ready", 32'(in_ready), 32'b1000);
    step();
    in_valid = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("done_held_%0d", k), 32'(out_done), 32'd0);
      check($sformatf("done_buf_%0d", k), 32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    #1;
    check("done_drain_cycle", 32'(out_done), 32'd0);
    check("done_drained", 32'(out_valid), 32'd0);
    step();
    #1;
    check("done_set", 32'(out_done), 32'd1);
    check("done_count", 32'(beat_count), 32'd5);
    clear   = 1'b1;
    step();
    clear   = 1'b0;
    in_done = '0;
    #1;
    check("clear_done", 32'(out_done), 32'd0);
    step();
    #1;
    check("clear_priority", 32'(out_done), 32'd0);

    // Counter wrap: 17 beats through a 4-bit counter
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 4'b0001;
    for (int k = 0; k < 17; k++) step();
    in_valid = '0;
    step();
    #1;
    check("wrap_count", 32'(beat_count), 32'd1);

    // Reset with a buffered beat (ptr is 1 before reset)
    in_valid = 4'b0001;
    step();
    #1;
    check("mid_valid_pre", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_ready_in_reset", 32'(in_ready), 32'h0);
    step();
    reset    = 1'b0;
    in_valid = 4'b1111;
    #1;
    check("mid_valid_post", 32'(out_valid), 32'd0);
    check("mid_count_post", 32'(beat_count), 32'd0);
    check("mid_ptr_post", 32'(in_ready), 32'b0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
